// File: rtl/bram_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : bram_stream_reader                                         |
// | Description : Burst read controller for a 2-cycle-latency block RAM.     |
// |               Turns a (base, length) request into a valid/ready stream   |
// |               through a credit-limited output FIFO.                      |
// |               Optional: define BRAM_STREAM_LAST_EN to add OutLast.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bram_stream_reader #(
    parameter int AddrWidth = 12,
    parameter int DataWidth = 8,
    parameter int FifoDepth = 4
) (
    input  logic                 clka,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [AddrWidth-1:0] BaseAddr,
    input  logic [AddrWidth:0]   Length,
    output logic                 Busy,
    output logic                 Done,
    output logic                 ena,
    output logic                 wea,
    output logic                 regcea,
    output logic [AddrWidth-1:0] addra,
    input  logic [DataWidth-1:0] Regdouta,
    output logic                 OutValid,
    output logic [DataWidth-1:0] OutData,
`ifdef BRAM_STREAM_LAST_EN
    output logic                 OutLast,
`endif
    input  logic                 OutReady
);

    localparam int c_PTR_W = $clog2(FifoDepth);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [AddrWidth:0]   r_remain;
    logic                 r_done;
    logic [1:0]           r_pipe;
    logic [DataWidth-1:0] r_mem [FifoDepth];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;

    logic [c_CNT_W:0]     w_credit_used;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_pop;

    // Every word already read but not yet delivered holds a FIFO slot in
    // reserve; a pop in the current cycle is deliberately not credited.
    assign w_credit_used = {1'b0, r_count}
                         + (c_CNT_W+1)'(r_pipe[0])
                         + (c_CNT_W+1)'(r_pipe[1]);
    assign w_issue    = (r_state == ISSUE) && (w_credit_used < (c_CNT_W+1)'(FifoDepth));
    assign w_push     = r_pipe[1];
    assign w_pop      = OutValid && OutReady;
    // Nothing left in the pipe and this pop empties the FIFO: burst complete.
    assign w_last_pop = (r_pipe == 2'b00) && (r_count == c_CNT_W'(1)) && w_pop;

    // ena is a decode of registered state so the read goes out in the cycle
    // right after Start is accepted.
    assign ena      = w_issue;
    assign wea      = 1'b0;
    assign regcea   = r_pipe[0];
    assign addra    = r_addr;
    assign Busy     = (r_state != IDLE);
    assign Done     = r_done;
    assign OutValid = (r_count != '0);
    assign OutData  = r_mem[r_rptr];

    // Burst control: capture request, step address/remaining per read, finish.
    always_ff @(posedge clka) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        if (Length != '0) begin
                            r_state  <= ISSUE;
                            r_addr   <= BaseAddr;
                            r_remain <= Length;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + AddrWidth'(1);
                        r_remain <= r_remain - (AddrWidth+1)'(1);
                        if (r_remain == (AddrWidth+1)'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read-latency tracker: stage 1 enables the RAM output register, stage 2
    // marks Regdouta as valid for a FIFO push.
    always_ff @(posedge clka) begin
        if (Reset) begin
            r_pipe <= 2'b00;
        end else begin
            r_pipe <= {r_pipe[0], w_issue};
        end
    end

    // Output FIFO; storage is cleared on reset so OutData reads back as zero.
    always_ff @(posedge clka) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= Regdouta;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef BRAM_STREAM_LAST_EN
    logic [AddrWidth:0] r_outrem;

    assign OutLast = OutValid && (r_outrem == (AddrWidth+1)'(1));

    // Words still to be handed downstream; the final one is flagged.
    always_ff @(posedge clka) begin
        if (Reset) begin
            r_outrem <= '0;
        end else if ((r_state == IDLE) && Start) begin
            r_outrem <= Length;
        end else if (w_pop) begin
            r_outrem <= r_outrem - (AddrWidth+1)'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_bram_stream_reader                                      |
// | Description : Scoreboard bench for bram_stream_reader with a 2-cycle     |
// |               behavioural RAM holding Mem[a] = a[7:0].                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bram_stream_reader;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int FD = 4;

    logic          clka = 1'b0;
    logic          Reset;
    logic          Start;
    logic [AW-1:0] BaseAddr;
    logic [AW:0]   Length;
    logic          Busy;
    logic          Done;
    logic          ena;
    logic          wea;
    logic          regcea;
    logic [AW-1:0] addra;
    logic [DW-1:0] Regdouta;
    logic          OutValid;
    logic [DW-1:0] OutData;
    logic          OutReady;
`ifdef BRAM_STREAM_LAST_EN
    logic          OutLast;
`endif

    bram_stream_reader #(
        .AddrWidth(AW),
        .DataWidth(DW),
        .FifoDepth(FD)
    ) dut (
        .clka     (clka),
        .Reset    (Reset),
        .Start    (Start),
        .BaseAddr (BaseAddr),
        .Length   (Length),
        .Busy     (Busy),
        .Done     (Done),
        .ena      (ena),
        .wea      (wea),
        .regcea   (regcea),
        .addra    (addra),
        .Regdouta (Regdouta),
        .OutValid (OutValid),
        .OutData  (OutData),
`ifdef BRAM_STREAM_LAST_EN
        .OutLast  (OutLast),
`endif
        .OutReady (OutReady)
    );

    always #5 clka = ~clka;

    // Behavioural RAM: Mem[a] = a[7:0], read register then output register.
    logic [DW-1:0] ram_stage1;
    always @(posedge clka) begin
        if (ena && !wea) ram_stage1 <= addra[DW-1:0];
        if (regcea)      Regdouta   <= ram_stage1;
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;
    exp_t sb_q[$];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor bookkeeping
    int            start_cyc = 0;
    int            first_valid_rel = -1;
    int            done_rel = -1;
    int            done_cnt = 0;
    int            hs_cnt = 0;
    int            last_hs_rel = -1;
    int            ena_cnt = 0;
    int            busy_cnt = 0;
    int            issued = 0;
    int            popped = 0;
    int            credit_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] addr_log[$];

    // Monitor: pops the scoreboard on each handshake and watches the RAM side.
    always @(negedge clka) begin
        exp_t e;
        if (Reset) begin
            prev_stall = 1'b0;
            issued     = 0;
            popped     = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", OutValid, 1);
                check("stall_data", OutData, prev_data);
            end
            if (ena) begin
                ena_cnt++;
                addr_log.push_back(addra);
            end
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end
            if (OutValid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
            if ((issued - popped) + (ena ? 1 : 0) > FD) credit_viol++;
            if (ena) issued++;
            if (OutValid && OutReady) begin
                popped++;
                hs_cnt++;
                last_hs_rel = cyc - start_cyc;
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got 0x%0h expected none (cycle %0d)", OutData, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("data", OutData, e.data);
`ifdef BRAM_STREAM_LAST_EN
                    check("last", OutLast, e.last);
`endif
                end
            end
            prev_stall = OutValid && !OutReady;
            prev_data  = OutData;
        end
    end

    // OutReady driver: 0 = always ready, 1 = fixed stall pattern, 2 = never ready
    int          ready_mode = 0;
    int          rk = 0;
    logic [15:0] pat = 16'b1001_1100_0110_1001;
    initial begin
        OutReady = 1'b1;
        forever begin
            @(posedge clka);
            #1;
            case (ready_mode)
                1:       OutReady = pat[rk % 16];
                2:       OutReady = 1'b0;
                default: OutReady = 1'b1;
            endcase
            rk++;
        end
    end

    task automatic start_burst(input logic [AW-1:0] base, input logic [AW:0] len);
        exp_t e;
        for (int i = 0; i < int'(len); i++) begin
            e.data = DW'(int'(base) + i);
            e.last = (i == int'(len) - 1);
            sb_q.push_back(e);
        end
        first_valid_rel = -1;
        done_cnt        = 0;
        done_rel        = -1;
        hs_cnt          = 0;
        last_hs_rel     = -1;
        ena_cnt         = 0;
        busy_cnt        = 0;
        addr_log.delete();
        start_cyc = cyc;
        BaseAddr  = base;
        Length    = len;
        Start     = 1'b1;
        @(posedge clka);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles && done_cnt == 0; i++) @(posedge clka);
        repeat (3) @(posedge clka);
        #1;
        check("done_pulses", done_cnt, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_Busy"}, Busy, 0);
        check({tag, "_Done"}, Done, 0);
        check({tag, "_ena"}, ena, 0);
        check({tag, "_wea"}, wea, 0);
        check({tag, "_regcea"}, regcea, 0);
        check({tag, "_addra"}, addra, 0);
        check({tag, "_OutValid"}, OutValid, 0);
        check({tag, "_OutData"}, OutData, 0);
`ifdef BRAM_STREAM_LAST_EN
        check({tag, "_OutLast"}, OutLast, 0);
`endif
    endtask

    logic [AW-1:0] exp_addr[4];

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        BaseAddr = '0;
        Length   = '0;
        repeat (3) @(posedge clka);
        #1;
        Reset = 1'b0;
        @(negedge clka);
        check_reset_outputs("reset");
        @(posedge clka);
        #1;

        // Basic burst, full rate
        start_burst(12'h010, 13'd8);
        wait_done(100);
        check("t1_first_valid", first_valid_rel, 4);
        check("t1_words", hs_cnt, 8);
        check("t1_last_hs", last_hs_rel, 11);
        check("t1_done_rel", done_rel, 12);
        check("t1_sb_empty", sb_q.size(), 0);

        // Address wrap
        exp_addr[0] = 12'hFFE;
        exp_addr[1] = 12'hFFF;
        exp_addr[2] = 12'h000;
        exp_addr[3] = 12'h001;
        start_burst(12'hFFE, 13'd4);
        wait_done(100);
        check("t2_reads", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) check("t2_addra", addr_log[i], exp_addr[i]);
        check("t2_words", hs_cnt, 4);
        check("t2_done_after_last", done_rel, last_hs_rel + 1);

        // Backpressure
        ready_mode = 1;
        start_burst(12'h200, 13'd16);
        wait_done(400);
        ready_mode = 0;
        check("t3_words", hs_cnt, 16);
        check("t3_credit_viol", credit_viol, 0);
        check("t3_sb_empty", sb_q.size(), 0);
        check("t3_done_after_last", done_rel, last_hs_rel + 1);

        // Zero-length request
        start_burst(12'h123, 13'd0);
        wait_done(20);
        check("t4_done_rel", done_rel, 1);
        check("t4_ena_cnt", ena_cnt, 0);
        check("t4_busy_cnt", busy_cnt, 0);

        // Reset in cycle 6 of a 20-word burst
        ready_mode = 2;
        start_burst(12'h100, 13'd20);
        repeat (5) @(posedge clka);
        #1;
        Reset = 1'b1;
        @(posedge clka);
        #1;
        Reset = 1'b0;
        sb_q.delete();
        @(negedge clka);
        check_reset_outputs("midreset");
        repeat (10) @(posedge clka);
        #1;
        check("t5_no_done", done_cnt, 0);
        ready_mode = 0;
        @(posedge clka);
        #1;
        start_burst(12'h3FF, 13'd2);
        wait_done(100);
        check("t5_words", hs_cnt, 2);
        check("t5_sb_empty", sb_q.size(), 0);

`ifdef BRAM_STREAM_LAST_EN
        // Final-word flag
        start_burst(12'h050, 13'd3);
        wait_done(100);
        check("t6_words", hs_cnt, 3);
`endif

        check("credit_viol_total", credit_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller placed directly upstream of the behavioural block RAM. It drives the RAM's `ena`/`regcea`/`addra` and consumes the registered output `Regdouta`, turning a (base, length) burst request into a valid/ready word stream. A credit-limited output FIFO absorbs the RAM's fixed 2-cycle read latency, so downstream backpressure never loses a word.

## Interface
- `AddrWidth`, 12, RAM address width; must equal the RAM instance's value.
- `DataWidth`, 8, RAM/stream word width.
- `FifoDepth`, 4, output FIFO entries; power of two, ≥4 (4 gives full rate).
- `clka`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high; one clock, one reset.
- `Start`  in  1  burst request, sampled when idle.
- `BaseAddr`  in  AddrWidth  first address, captured on an accepted Start.
- `Length`  in  AddrWidth+1  word count, 0..2^AddrWidth, captured on an accepted Start.
- `Busy`  out  1  burst in progress.
- `Done`  out  1  one-cycle pulse at burst completion.
- `ena`  out  1  RAM enable; a read is issued in each cycle it is high.
- `wea`  out  1  tied 0.
- `regcea`  out  1  RAM output-register enable.
- `addra`  out  AddrWidth  RAM address.
- `Regdouta`  in  DataWidth  RAM registered read data.
- `OutValid`  out  1  stream word available.
- `OutData`  out  DataWidth  stream word.
- `OutReady`  in  1  downstream accept.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE, Start=1:
  - Length≠0 → ISSUE; capture BaseAddr/Length; Busy=1.
  - Length=0 → stays IDLE; Done pulses the next cycle; no RAM access.
- Start is ignored while Busy.
- ISSUE:
  - A read is issued (`ena`=1, `addra`=current address) only when count+inflight < FifoDepth.
    - count = FIFO occupancy.
    - inflight = number of set read-pipeline valid bits (0..2).
    - A same-cycle pop is not credited.
  - After each read: address +1, wrapping modulo 2^AddrWidth; remaining count −1.
  - When remaining reaches 0 → DRAIN.
- Read pipeline: a 2-bit valid shift register.
  - Stage-1 valid drives `regcea`.
  - Stage-2 valid pushes `Regdouta` into the FIFO.
- DRAIN: when inflight=0, FIFO empty, and the last word has been handshaken → Done=1 for one cycle, Busy=0 → IDLE.
- Stream:
  - A word transfers when OutValid & OutReady.
  - OutData/OutValid hold steady while OutValid & !OutReady.
  - Words are delivered in address order, none dropped or duplicated.
- FIFO push and pop in the same cycle leave count unchanged. Overflow cannot occur by construction; the bench asserts it never does.

## Timing
- Reset values: Busy=0, Done=0, ena=0, wea=0, regcea=0, addra=0, OutValid=0, OutData=0. FIFO, pipeline and counters cleared.
- Reset mid-burst: in-flight reads are discarded, the FIFO is flushed, state → IDLE, and no Done is generated.
- First-word latency, with Start high in cycle 0:
  - cycle 1: ena=1, addra=BaseAddr
  - cycle 2: regcea=1
  - cycle 3: Regdouta valid, pushed at the end of the cycle
  - cycle 4: OutValid=1
- Steady state with OutReady held high and FifoDepth≥4: one word per cycle.
- Done is asserted the cycle after the final handshake. A new Start is accepted in the Done cycle.

## Configuration
- `BRAM_STREAM_LAST_EN` defined:
  - adds output `OutLast` (1 bit), high together with OutValid on the final word of a burst only;
  - reset value 0.
- Undefined: port absent; Done is the only end-of-burst indication.

## Test plan
- Reset, then Start with BaseAddr=0x010, Length=8, RAM preloaded Mem[a]=a[7:0], OutReady=1:
  - OutValid first high in cycle 4;
  - stream 0x10..0x17 on consecutive cycles;
  - Done one cycle after the last word.
- BaseAddr=0xFFE, Length=4:
  - addra sequence FFE, FFF, 000, 001;
  - data 0xFE, 0xFF, 0x00, 0x01.
- Length=16 with OutReady toggling 1-0-0-1 pseudo-randomly:
  - all 16 words delivered in order with no gaps or duplicates;
  - count+inflight never exceeds FifoDepth;
  - OutData stable while stalled.
- Length=0: Done pulses in cycle 1, ena never asserted, Busy stays 0.
- Reset asserted in cycle 6 of a Length=20 burst:
  - all outputs return to reset values the next cycle;
  - no Done;
  - a following Start with Length=2 delivers exactly 2 correct words.
- With `BRAM_STREAM_LAST_EN`, Length=3: OutLast high only on the third handshake.
